// File: rtl/tw_cpu_gen.sv
// Parametrised TW accumulator core: banked user/priv A/B/C, precise traps, terminal HALT.
// Build option: define TW_IRQ_EN to enable the external interrupt and its pending latch.
module tw_cpu_gen #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int MODE_W = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [MODE_W+ADDR_W-1:0] addr,
  input  logic [DATA_W+3:0]        data,
  input  logic [DATA_W-1:0]        in,
  output logic [DATA_W-1:0]        out,
  input  logic                     irq,
  output logic [1:0]               cause,
  output logic                     halted
);

  localparam logic [MODE_W-1:0] MODE_USER = '0;
  localparam logic [MODE_W-1:0] MODE_PRIV = MODE_W'(1);
  localparam logic [1:0] CAUSE_SWI = 2'd1;
  localparam logic [1:0] CAUSE_EXC = 2'd2;
  localparam logic [1:0] CAUSE_IRQ = 2'd3;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t                     state_q, state_d;
  logic [MODE_W+ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]          out_q, out_d;
  logic [1:0]                 cause_q, cause_d;
  logic [ADDR_W-1:0]          saved_ip_q, saved_ip_d;
  logic [DATA_W-1:0]          a_q [2];
  logic [DATA_W-1:0]          a_d [2];
  logic [DATA_W-1:0]          b_q [2];
  logic [DATA_W-1:0]          b_d [2];
  logic                       c_q [2];
  logic                       c_d [2];

  logic [3:0]        opcode;
  logic [DATA_W-1:0] imm;
  logic [MODE_W-1:0] mode;
  logic [ADDR_W-1:0] pc, pc_inc, target;
  logic              priv;
  logic              non_imm, is_jump, jump_taken, imm_hi, seq_next, illegal;
  logic [DATA_W:0]   sum_a, sum_b;
  logic              irq_take;

  assign opcode = data[DATA_W+3:DATA_W];
  assign imm    = data[DATA_W-1:0];
  assign mode   = addr_q[MODE_W+ADDR_W-1:ADDR_W];
  assign pc     = addr_q[ADDR_W-1:0];
  assign pc_inc = pc + ADDR_W'(1);
  assign target = imm[ADDR_W-1:0];
  assign priv   = |mode;

  assign sum_a = {1'b0, a_q[priv]} + {1'b0, imm};
  assign sum_b = {1'b0, b_q[priv]} + {1'b0, imm};

  always_comb begin
    non_imm = 1'b0;
    case (opcode)
      4'h1, 4'h2, 4'h4, 4'h6, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD: non_imm = 1'b1;
      default: non_imm = 1'b0;
    endcase
  end

  assign is_jump    = (opcode == 4'hE) || (opcode == 4'hF);
  assign jump_taken = (opcode == 4'hF) || ((opcode == 4'hE) && !c_q[priv]);
  assign imm_hi     = (imm >> ADDR_W) != '0;
  // Only sequential flow can run off the end of the address space; taken jumps and IRET cannot.
  assign seq_next   = !((is_jump && jump_taken) || ((opcode == 4'hD) && priv));
  assign illegal    = (non_imm && (imm != '0)) ||
                      ((opcode == 4'hC) && !priv) ||
                      (is_jump && imm_hi) ||
                      (seq_next && (&pc));

`ifdef TW_IRQ_EN
  logic irq_pend_q, irq_pend_d;
  assign irq_take = (state_q == ST_RUN) && !priv && (irq || irq_pend_q);
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_take   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    out_d      = out_q;
    cause_d    = cause_q;
    saved_ip_d = saved_ip_q;
    for (int i = 0; i < 2; i++) begin
      a_d[i] = a_q[i];
      b_d[i] = b_q[i];
      c_d[i] = c_q[i];
    end
`ifdef TW_IRQ_EN
    irq_pend_d = irq_pend_q | irq;
`endif
    if (state_q == ST_RUN) begin
      addr_d = {mode, pc_inc};
      if (illegal) begin
        if (priv) begin
          state_d = ST_HALT;
          addr_d  = addr_q;
        end else begin
          saved_ip_d = pc;
          addr_d     = {MODE_PRIV, ADDR_W'(1)};
          cause_d    = CAUSE_EXC;
        end
      end else if ((opcode == 4'hD) && !priv) begin
        saved_ip_d = pc_inc;
        addr_d     = {MODE_PRIV, ADDR_W'(0)};
        cause_d    = CAUSE_SWI;
      end else if (irq_take) begin
        // The fetched instruction is discarded and re-fetched after IRET.
        saved_ip_d = pc;
        addr_d     = {MODE_PRIV, ADDR_W'(2)};
        cause_d    = CAUSE_IRQ;
`ifdef TW_IRQ_EN
        irq_pend_d = 1'b0;
`endif
      end else begin
        case (opcode)
          4'h0: begin
            a_d[priv] = sum_a[DATA_W-1:0];
            c_d[priv] = sum_a[DATA_W];
          end
          4'h1: a_d[priv] = b_q[priv];
          4'h2: a_d[priv] = in;
          4'h3: a_d[priv] = imm;
          4'h4: b_d[priv] = a_q[priv];
          4'h5: begin
            b_d[priv] = sum_b[DATA_W-1:0];
            c_d[priv] = sum_b[DATA_W];
          end
          4'h6: b_d[priv] = in;
          4'h7: b_d[priv] = imm;
          4'h9: out_d = b_q[priv];
          4'hB: out_d = imm;
          4'hC: begin
            a_d[0] = a_q[1];
            a_d[1] = a_q[0];
          end
          4'hD: addr_d = {MODE_USER, saved_ip_q};
          4'hE, 4'hF: if (jump_taken) addr_d = {mode, target};
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      addr_q     <= '0;
      out_q      <= '0;
      cause_q    <= '0;
      saved_ip_q <= '0;
      for (int i = 0; i < 2; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= 1'b0;
      end
`ifdef TW_IRQ_EN
      irq_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      out_q      <= out_d;
      cause_q    <= cause_d;
      saved_ip_q <= saved_ip_d;
      for (int i = 0; i < 2; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
        c_q[i] <= c_d[i];
      end
`ifdef TW_IRQ_EN
      irq_pend_q <= irq_pend_d;
`endif
    end
  end

  assign addr   = addr_q;
  assign out    = out_q;
  assign cause  = cause_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_tw_cpu_gen.sv
// Directed bench for tw_cpu_gen: default 4/4/2 core plus an 8/6/2 core for wrap and jump-range traps.
// Expectations for the interrupt phase follow whether TW_IRQ_EN is defined.
module tb_tw_cpu_gen;

  logic       clock;
  logic       reset;
  logic       irq;

  logic [5:0] addr;
  logic [7:0] data;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic [1:0] cause;
  logic       halted;

  logic [7:0]  addr8;
  logic [11:0] data8;
  logic [7:0]  in8;
  logic [7:0]  out8;
  logic [1:0]  cause8;
  logic        halted8;

  logic [7:0]  rom  [64];
  logic [11:0] rom8 [256];

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] p1_exp [13] = '{6'h01, 6'h02, 6'h03, 6'h10, 6'h04, 6'h05, 6'h06,
                              6'h07, 6'h11, 6'h12, 6'h13, 6'h14, 6'h07};
`ifdef TW_IRQ_EN
  logic [5:0] p2_exp   [7] = '{6'h01, 6'h02, 6'h12, 6'h02, 6'h12, 6'h02, 6'h03};
  logic [1:0] p2_cause [7] = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`else
  logic [5:0] p2_exp   [7] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07};
  logic [1:0] p2_cause [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
  logic [7:0] p4_exp [4] = '{8'h01, 8'h05, 8'h3F, 8'h41};

  assign data  = rom[addr];
  assign data8 = rom8[addr8];

  tw_cpu_gen dut (
    .clock  (clock),
    .reset  (reset),
    .addr   (addr),
    .data   (data),
    .in     (in_port),
    .out    (out_port),
    .irq    (irq),
    .cause  (cause),
    .halted (halted)
  );

  tw_cpu_gen #(.DATA_W(8), .ADDR_W(6), .MODE_W(2)) dut8 (
    .clock  (clock),
    .reset  (reset),
    .addr   (addr8),
    .data   (data8),
    .in     (in8),
    .out    (out8),
    .irq    (irq),
    .cause  (cause8),
    .halted (halted8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 8'h80;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    irq     = 1'b0;
    in_port = 4'h0;
    in8     = 8'h00;
    clear_rom();
    for (int i = 0; i < 256; i++) rom8[i] = 12'h800;
    rom8[8'h00] = 12'h001;  // ADD A,1 -> C=0
    rom8[8'h01] = 12'hE05;  // JNC 5 taken
    rom8[8'h05] = 12'hF3F;  // JMP 63
    rom8[8'h3F] = 12'h800;  // NOP at last pc -> wrap trap
    rom8[8'h41] = 12'hF40;  // priv JMP with out-of-range target -> HALT

    // Phase 1: arithmetic, SWI/IRET round trip, user exception
    rom[6'h00] = 8'h35;
    rom[6'h01] = 8'h0C;
    rom[6'h02] = 8'hE0;
    rom[6'h03] = 8'hD0;
    rom[6'h04] = 8'hE0;
    rom[6'h05] = 8'h79;
    rom[6'h06] = 8'h90;
    rom[6'h07] = 8'h11;
    rom[6'h10] = 8'hD0;
    rom[6'h11] = 8'hC0;
    rom[6'h12] = 8'h40;
    rom[6'h13] = 8'h90;
    rom[6'h14] = 8'hD0;
    do_reset();
    check("reset_addr", addr, 6'h00);
    check("reset_out", out_port, 4'h0);
    check("reset_cause", cause, 2'd0);
    check("reset_halted", halted, 1'b0);
    check("reset_addr8", addr8, 8'h00);
    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("p1_addr[%0d]", i), addr, p1_exp[i]);
      if (i == 3) check("p1_swi_cause", cause, 2'd1);
      if (i == 7) check("p1_out_b9", out_port, 4'h9);
      if (i == 8) begin
        check("p1_exc_cause", cause, 2'd2);
        check("p1_exc_out", out_port, 4'h9);
      end
      if (i == 11) check("p1_userA_kept", out_port, 4'h1);
      if (i == 12) check("p1_halted", halted, 1'b0);
    end

    // Phase 2: interrupt taken at pc 2, then re-raised while privileged
    clear_rom();
    rom[6'h00] = 8'h35;
    rom[6'h12] = 8'hD0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      irq = (i == 2) || (i == 3);
      tick();
      check($sformatf("p2_addr[%0d]", i), addr, p2_exp[i]);
      check($sformatf("p2_cause[%0d]", i), cause, p2_cause[i]);
    end
    irq = 1'b0;

    // Phase 3: privileged illegal opcode -> HALT, then async reset
    clear_rom();
    rom[6'h00] = 8'hD0;
    rom[6'h10] = 8'hB6;
    rom[6'h11] = 8'h83;
    do_reset();
    tick();
    check("p3_swi_addr", addr, 6'h10);
    tick();
    check("p3_out6", out_port, 4'h6);
    tick();
    check("p3_halted", halted, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("p3_frz_addr[%0d]", i), addr, 6'h11);
      check($sformatf("p3_frz_out[%0d]", i), out_port, 4'h6);
      check($sformatf("p3_frz_halt[%0d]", i), halted, 1'b1);
    end
    reset = 1'b0;
    #1;
    check("p3_rst_addr", addr, 6'h00);
    check("p3_rst_halted", halted, 1'b0);
    check("p3_rst_out", out_port, 4'h0);
    check("p3_rst_cause", cause, 2'd0);

    // Phase 4: wide core, JNC taken, wrap trap, out-of-range jump in priv
    @(negedge clock);
    reset = 1'b1;
    check("p4_reset_addr8", addr8, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("p4_addr8[%0d]", i), addr8, p4_exp[i]);
    end
    check("p4_wrap_cause", cause8, 2'd2);
    tick();
    check("p4_halted8", halted8, 1'b1);
    check("p4_halt_addr8", addr8, 8'h41);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
